// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the LEGv8 fetch stage. The Controller reads the same
// opcode field bounds so that decode and fetch agree on the opcode slice.
package instruction_fetch_pkg;

    localparam int INSTR_WIDTH  = 32;
    localparam int ADDR_WIDTH   = 64;
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 21;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int PC_INCREMENT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundles the instruction-memory port, the decode output register and the
// branch-resolution inputs. The master modport is the fetch stage's view.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic                    imemReq;
    logic [ADDR_WIDTH-1:0]   imemAddr;
    logic                    imemReady;
    logic                    imemValid;
    logic [INSTR_WIDTH-1:0]  imemData;

    logic                    instrValid;
    logic                    instrReady;
    logic [INSTR_WIDTH-1:0]  instruction;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   instrPC;

    logic                    branchResolve;
    logic                    unconditionalBranch;
    logic                    branch;
    logic                    zero;
    logic [ADDR_WIDTH-1:0]   branchPC;
    logic [ADDR_WIDTH-1:0]   branchOffset;

    modport master (
        output imemReq, imemAddr, instrValid, instruction, opcode, instrPC,
        input  imemReady, imemValid, imemData, instrReady,
               branchResolve, unconditionalBranch, branch, zero, branchPC, branchOffset
    );

    modport slave (
        input  imemReq, imemAddr, instrValid, instruction, opcode, instrPC,
        output imemReady, imemValid, imemData, instrReady,
               branchResolve, unconditionalBranch, branch, zero, branchPC, branchOffset
    );

endinterface

// File: rtl/instruction_fetch_branch_target.sv
// Combinational branch decision and target address; kept separate so later
// pipelined fetch variants can reuse it unchanged.
module instruction_fetch_branch_target
    import instruction_fetch_pkg::*;
(
    input  logic                  branch_resolve_i,
    input  logic                  unconditional_branch_i,
    input  logic                  branch_i,
    input  logic                  zero_i,
    input  logic [ADDR_WIDTH-1:0] branch_pc_i,
    input  logic [ADDR_WIDTH-1:0] branch_offset_i,
    output logic                  pc_src_o,
    output logic [ADDR_WIDTH-1:0] target_o
);

    assign pc_src_o = branch_resolve_i & (unconditional_branch_i | (branch_i & zero_i));
    // Offset counts words; the shift drops its top bits, giving modulo-2^64 wrap.
    assign target_o = branch_pc_i + (branch_offset_i << 2);

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: single-outstanding instruction-memory reads feeding a
// valid/ready output register, with branch redirect that drops stale fetches.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 64'h0
) (
    input logic                 clock,
    input logic                 resetN,
    instruction_fetch_if.master bus
);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;

    logic                   pc_src;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   req;
    logic                   accepted;

    instruction_fetch_branch_target u_branch_target (
        .branch_resolve_i       (bus.branchResolve),
        .unconditional_branch_i (bus.unconditionalBranch),
        .branch_i               (bus.branch),
        .zero_i                 (bus.zero),
        .branch_pc_i            (bus.branchPC),
        .branch_offset_i        (bus.branchOffset),
        .pc_src_o               (pc_src),
        .target_o               (target)
    );

    // Issue only when the output register is empty or draining this cycle.
    assign req      = (state_q == ISSUE) && (!instr_valid_q || bus.instrReady);
    assign accepted = req && bus.imemReady;

    assign bus.imemReq     = req;
    assign bus.imemAddr    = pc_q;
    assign bus.instrValid  = instr_valid_q;
    assign bus.instruction = instruction_q;
    assign bus.opcode      = instruction_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.instrPC     = instr_pc_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q && !bus.instrReady;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            IDLE:  state_d = ISSUE;
            ISSUE: if (accepted) state_d = WAIT;
            WAIT: begin
                if (bus.imemValid) begin
                    instruction_d = bus.imemData;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_WIDTH'(PC_INCREMENT);
                    state_d       = ISSUE;
                end
            end
            DROP:  if (bus.imemValid) state_d = ISSUE;
            default: state_d = IDLE;
        endcase

        // A taken branch overrides everything above, including a response landing now.
        if (pc_src) begin
            pc_d          = target;
            instr_valid_d = 1'b0;
            instruction_d = instruction_q;
            instr_pc_d    = instr_pc_q;
            case (state_q)
                IDLE:    state_d = ISSUE;
                ISSUE:   state_d = accepted ? DROP : ISSUE;
                WAIT:    state_d = bus.imemValid ? ISSUE : DROP;
                DROP:    state_d = DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a variable-latency memory model feeds
// the fetch stage while decode stalls, branch redirects and reset are exercised.
module tb_instruction_fetch;

    logic clock;
    logic resetN;
    int   mem_lat;
    int   n_checks;
    int   n_pass;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(64'h100)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic set_branch(input logic uncond, input logic br, input logic z,
                              input logic [63:0] bpc, input logic [63:0] boff);
        bus.branchResolve       = 1'b1;
        bus.unconditionalBranch = uncond;
        bus.branch              = br;
        bus.zero                = z;
        bus.branchPC            = bpc;
        bus.branchOffset        = boff;
    endtask

    task automatic clear_branch();
        bus.branchResolve       = 1'b0;
        bus.unconditionalBranch = 1'b0;
        bus.branch              = 1'b0;
        bus.zero                = 1'b0;
        bus.branchPC            = '0;
        bus.branchOffset        = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(bus.instrValid), 64'h0);
        check({tag, "_instr"}, 64'(bus.instruction), 64'h0);
        check({tag, "_opcode"}, 64'(bus.opcode), 64'h0);
        check({tag, "_instr_pc"}, bus.instrPC, 64'h0);
        check({tag, "_req"}, 64'(bus.imemReq), 64'h0);
        check({tag, "_addr"}, bus.imemAddr, 64'h100);
    endtask

    task automatic check_out(input string tag, input logic [63:0] pc, input logic [31:0] word);
        check({tag, "_valid"}, 64'(bus.instrValid), 64'h1);
        check({tag, "_instr_pc"}, bus.instrPC, pc);
        check({tag, "_instr"}, 64'(bus.instruction), 64'(word));
        check({tag, "_opcode"}, 64'(bus.opcode), 64'h458);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [63:0] addr);
        check({tag, "_req"}, 64'(bus.imemReq), 64'(req));
        check({tag, "_addr"}, bus.imemAddr, addr);
    endtask

    // Memory model: response word is addr[31:0] ^ 32'h8B020120, so address 0x100 returns 32'h8B020020.
    initial begin : memory_model
        logic        pending;
        int          rem;
        logic        acc;
        logic [63:0] acc_addr;
        logic [63:0] req_addr;
        pending       = 1'b0;
        rem           = 0;
        req_addr      = '0;
        bus.imemValid = 1'b0;
        bus.imemData  = '0;
        forever begin
            @(posedge clock);
            acc      = resetN && bus.imemReq && bus.imemReady;
            acc_addr = bus.imemAddr;
            #2;
            bus.imemValid = 1'b0;
            if (!resetN) begin
                pending = 1'b0;
            end else begin
                if (acc) begin
                    pending  = 1'b1;
                    rem      = mem_lat;
                    req_addr = acc_addr;
                end
                if (pending) begin
                    rem--;
                    if (rem == 0) begin
                        bus.imemValid = 1'b1;
                        bus.imemData  = req_addr[31:0] ^ 32'h8B020120;
                        pending       = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        n_checks       = 0;
        n_pass         = 0;
        mem_lat        = 1;
        resetN         = 1'b1;
        bus.imemReady  = 1'b1;
        bus.instrReady = 1'b1;
        clear_branch();

        // Asynchronous reset values.
        #1 resetN = 1'b0;
        #1 check_reset_values("reset");

        @(negedge clock);
        resetN = 1'b1;
        #1 check("idle_req", 64'(bus.imemReq), 64'h0);

        // First fetch from RESET_PC with 1-cycle memory.
        @(negedge clock); check_req("first_issue", 1'b1, 64'h100);
        @(negedge clock); check_req("first_wait", 1'b0, 64'h100);
        check("first_wait_valid", 64'(bus.instrValid), 64'h0);
        @(negedge clock); check_out("first_out", 64'h100, 32'h8B020020);
        check_req("second_issue", 1'b1, 64'h104);

        // Decode stall: output held, no new request.
        bus.instrReady = 1'b0;
        #1 check("stall_req", 64'(bus.imemReq), 64'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_out("stall_hold", 64'h100, 32'h8B020020);
            check("stall_hold_req", 64'(bus.imemReq), 64'h0);
        end
        bus.instrReady = 1'b1;
        #1 check_req("release_issue", 1'b1, 64'h104);
        @(negedge clock); check("release_wait_valid", 64'(bus.instrValid), 64'h0);
        check("release_wait_req", 64'(bus.imemReq), 64'h0);
        @(negedge clock); check_out("second_out", 64'h104, 32'h8B020024);
        check_req("third_issue", 1'b1, 64'h108);

        // Unconditional redirect while a request is accepted: goes through DROP.
        set_branch(1'b1, 1'b0, 1'b0, 64'h200, 64'd3);
        @(negedge clock); clear_branch();
        check("uncond_valid", 64'(bus.instrValid), 64'h0);
        check_req("uncond_drop", 1'b0, 64'h20C);
        @(negedge clock); check_req("uncond_issue", 1'b1, 64'h20C);
        check("uncond_stale_valid", 64'(bus.instrValid), 64'h0);
        @(negedge clock); check("uncond_wait_req", 64'(bus.imemReq), 64'h0);
        @(negedge clock); check_out("target_out", 64'h20C, 32'h8B02032C);
        check_req("after_target_issue", 1'b1, 64'h210);

        // Conditional branch not taken: sequential fetch continues.
        set_branch(1'b0, 1'b1, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock); clear_branch();
        check_req("not_taken_wait", 1'b0, 64'h210);
        @(negedge clock); check_out("not_taken_out", 64'h210, 32'h8B020330);
        check_req("not_taken_issue", 1'b1, 64'h214);

        // Conditional branch taken with negative offset: target 0x1FC.
        set_branch(1'b0, 1'b1, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock); clear_branch();
        check("neg_valid", 64'(bus.instrValid), 64'h0);
        check_req("neg_drop", 1'b0, 64'h1FC);
        @(negedge clock); check_req("neg_issue", 1'b1, 64'h1FC);
        @(negedge clock); check("neg_wait_req", 64'(bus.imemReq), 64'h0);
        @(negedge clock); check_out("neg_out", 64'h1FC, 32'h8B0200DC);
        check_req("neg_next_issue", 1'b1, 64'h200);

        // 3-cycle memory, redirect while in WAIT: stale response must be dropped.
        mem_lat = 3;
        @(negedge clock); check("slow_wait_req", 64'(bus.imemReq), 64'h0);
        set_branch(1'b1, 1'b0, 1'b0, 64'h200, 64'd3);
        @(negedge clock); clear_branch();
        check("slow_drop_valid", 64'(bus.instrValid), 64'h0);
        check_req("slow_drop", 1'b0, 64'h20C);
        @(negedge clock); check_req("slow_stale_cycle", 1'b0, 64'h20C);
        check("slow_stale_valid", 64'(bus.instrValid), 64'h0);
        @(negedge clock); check_req("slow_issue", 1'b1, 64'h20C);
        check("slow_issue_valid", 64'(bus.instrValid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("slow_pending_valid", 64'(bus.instrValid), 64'h0);
        end
        @(negedge clock); check_out("slow_out", 64'h20C, 32'h8B02032C);
        check_req("slow_next_issue", 1'b1, 64'h210);

        // Reset mid-WAIT: outputs return to reset values immediately, fetch restarts.
        @(negedge clock);
        #1 resetN = 1'b0;
        #1 check_reset_values("mid_reset");
        mem_lat = 1;
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        #1 check("restart_idle_req", 64'(bus.imemReq), 64'h0);
        @(negedge clock); check_req("restart_issue", 1'b1, 64'h100);
        @(negedge clock); check("restart_wait_req", 64'(bus.imemReq), 64'h0);
        @(negedge clock); check_out("restart_out", 64'h100, 32'h8B020020);
        check_req("restart_next_issue", 1'b1, 64'h104);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
